// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding and line-level
//               constants used by both the transmit and receive blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame FSM states; encoding shared with the receive FSM.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // A prescale of zero would never finish a bit, so it is run as one cycle per bit.
  function automatic logic [3:0] eff_prescale(input logic [3:0] prescale);
    return (prescale == 4'd0) ? 4'd1 : prescale;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_bit_timer
// Description : Per-bit cycle counter and data bit index for the UART
//               transmitter. Flags the last cycle of each bit and the last
//               data bit, and exposes the index the next cycle will use.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,          // a frame is in flight
  input  logic             data_phase_i,   // currently sending data bits
  input  logic [3:0]       prescale_i,     // cycles per bit, already non-zero
  output logic             bit_done_o,
  output logic             last_data_bit_o,
  output logic [IDX_W-1:0] bit_idx_next_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       last_cnt;

  assign last_cnt        = prescale_i - 4'd1;
  assign bit_done_o      = (cnt_q == last_cnt);
  assign last_data_bit_o = (idx_q == LAST_IDX);
  assign bit_idx_next_o  = idx_d;

  // Next counter/index: hold at zero when idle, wrap the counter at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!run_i) begin
      cnt_d = 4'd0;
      idx_d = '0;
    end else if (bit_done_o) begin
      cnt_d = 4'd0;
      if (data_phase_i) begin
        idx_d = last_data_bit_o ? '0 : idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter and index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule : uart_tx_bit_timer
`default_nettype wire

// File: rtl/uart_tx_top.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_top
// Description : UART transmitter. Accepts a byte when idle, then sends
//               start, DATA_WIDTH data bits LSB first, optional parity and
//               one stop bit, each held for Prescale clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  input  logic [3:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic [3:0]            prescale_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  bit_done;
  logic                  last_data_bit;
  logic [IDX_W-1:0]      bit_idx_next;
  logic                  parity_bit;

  assign accept     = (state_q == IDLE) && Data_Valid && !busy_q;
  assign parity_bit = (par_type_q == PARITY_ODD) ? ~^data_q : ^data_q;

  uart_tx_bit_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bit_timer (
    .clk_i           (Clk),
    .rst_i           (Rst),
    .run_i           (state_q != IDLE),
    .data_phase_i    (state_q == DATA),
    .prescale_i      (prescale_q),
    .bit_done_o      (bit_done),
    .last_data_bit_o (last_data_bit),
    .bit_idx_next_o  (bit_idx_next)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each non-idle state lasts until the timer flags its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                    state_d = START;
      START:   if (bit_done)                  state_d = DATA;
      DATA:    if (bit_done && last_data_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done)                  state_d = STOP;
      STOP:    if (bit_done)                  state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so TX_OUT/Busy can be registered without lag.
  always_comb begin
    tx_d   = STOP_BIT;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = data_q[bit_idx_next];
      PARITY:  tx_d = parity_bit;
      default: tx_d = STOP_BIT;
    endcase
  end

  // Shadow copy of the request, frozen for the whole frame.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      prescale_q <= 4'd1;
    end else if (accept) begin
      data_q     <= P_DATA;
      par_en_q   <= Parity_EN;
      par_type_q <= Parity_type;
      prescale_q <= eff_prescale(Prescale);
    end
  end

  // Output flops; line idles high.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_q   <= STOP_BIT;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule : uart_tx_top
`default_nettype wire

// File: tb/tb_uart_tx_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_top
// Description : Scoreboard bench for uart_tx_top. Stimulus pushes the expected
//               serial frame; a line monitor checks every cycle of each frame,
//               the Busy window and the idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_top;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_EN;
  logic       Parity_type;
  logic [3:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  typedef struct {
    logic [11:0] bits;      // line levels, index 0 sent first
    int          nbits;
    int          p;         // cycles per bit
    int          abort_at;  // >0: frame is cut by reset after this many cycles
    bit          gap_chk;   // must follow the previous frame after exactly one idle cycle
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_tx_top #(.DATA_WIDTH(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .Prescale    (Prescale),
    .TX_OUT      (TX_OUT),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference framing: start, data LSB first, parity from a bit count, stop.
  function automatic exp_t make_exp(input logic [7:0] d, input logic pen, input logic pt,
                                    input int p, input int abort_at, input bit gap);
    exp_t e;
    int   ones;
    e.bits = '1;
    e.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      e.bits[i+1] = d[i];
      if (d[i]) ones++;
    end
    if (pen) e.bits[9] = ((ones % 2) == 1) ^ pt;
    e.nbits    = pen ? 11 : 10;
    e.p        = p;
    e.abort_at = abort_at;
    e.gap_chk  = gap;
    return e;
  endfunction

  function automatic exp_t hand_exp(input logic [11:0] bits, input int nbits, input int p);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.p = p; e.abort_at = 0; e.gap_chk = 1'b0;
    return e;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (Busy) begin
      @(posedge Clk); #2;
      k++;
      if (k > 400) begin
        check("wait_idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Issue one single-cycle request and register its expected frame.
  task automatic send(input logic [7:0] d, input logic pen, input logic pt,
                      input logic [3:0] presc, input exp_t e);
    wait_idle();
    P_DATA = d; Parity_EN = pen; Parity_type = pt; Prescale = presc;
    Data_Valid = 1'b1;
    q.push_back(e);
    @(posedge Clk); #2;
    Data_Valid = 1'b0;
  endtask

  // Line monitor / scoreboard.
  initial begin : monitor
    exp_t e;
    int   idle;
    int   lim;
    int   k;
    idle = 0;
    forever begin
      @(negedge Clk);
      if (Busy !== 1'b1) begin
        idle++;
      end else if (q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        k = 0;
        while (Busy === 1'b1 && k < 400) begin @(negedge Clk); k++; end
        idle = 1;
      end else begin
        e = q.pop_front();
        if (e.gap_chk) check("idle_gap", idle, 1);
        lim = (e.abort_at > 0) ? e.abort_at : e.nbits * e.p;
        for (int c = 0; c < lim; c++) begin
          if (c > 0) @(negedge Clk);
          check("tx_bit", {31'd0, TX_OUT}, {31'd0, e.bits[c / e.p]});
          check("busy_high", {31'd0, Busy}, 1);
        end
        @(negedge Clk);
        check("tx_idle_after", {31'd0, TX_OUT}, 1);
        check("busy_low_after", {31'd0, Busy}, 0);
        idle = 1;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] d;
    int         m;

    // Reset held with a pending request.
    Rst = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h5A;
    Parity_EN = 1'b0; Parity_type = 1'b0; Prescale = 4'd8;
    repeat (3) begin
      @(negedge Clk);
      check("reset_tx", {31'd0, TX_OUT}, 1);
      check("reset_busy", {31'd0, Busy}, 0);
    end
    @(posedge Clk); #2;
    Rst = 1'b0;
    q.push_back(make_exp(8'h5A, 1'b0, 1'b0, 8, 0, 1'b0));
    @(posedge Clk); #2;
    Data_Valid = 1'b0;

    // Hand-computed frames.
    send(8'hA7, 1'b0, 1'b0, 4'd8, hand_exp(12'h34E, 10, 8));
    send(8'h66, 1'b1, 1'b0, 4'd8, hand_exp(12'h4CC, 11, 8));
    send(8'hCC, 1'b1, 1'b1, 4'd8, hand_exp(12'h798, 11, 8));

    // Data_Valid held across two frames with inputs changed mid-frame.
    wait_idle();
    P_DATA = 8'h3C; Parity_EN = 1'b0; Parity_type = 1'b0; Prescale = 4'd8;
    Data_Valid = 1'b1;
    q.push_back(make_exp(8'h3C, 1'b0, 1'b0, 8, 0, 1'b0));
    @(posedge Clk); #2;
    repeat (20) @(posedge Clk);
    #2;
    P_DATA = 8'hE1; Prescale = 4'd4;
    q.push_back(make_exp(8'hE1, 1'b0, 1'b0, 4, 0, 1'b1));
    wait_idle();
    @(posedge Clk); #2;
    Data_Valid = 1'b0;

    // Reset pulse during data bit 3, then a clean frame.
    wait_idle();
    P_DATA = 8'h96; Parity_EN = 1'b1; Parity_type = 1'b0; Prescale = 4'd8;
    Data_Valid = 1'b1;
    q.push_back(make_exp(8'h96, 1'b1, 1'b0, 8, 34, 1'b0));
    @(posedge Clk); #2;
    Data_Valid = 1'b0;
    repeat (33) @(posedge Clk);
    #2;
    Rst = 1'b1;
    @(posedge Clk); #2;
    Rst = 1'b0;
    send(8'h5B, 1'b1, 1'b1, 4'd8, make_exp(8'h5B, 1'b1, 1'b1, 8, 0, 1'b0));

    // Random bytes across all four parity settings.
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      m = i % 4;
      send(d, m[1], m[0], 4'd8, make_exp(d, m[1], m[0], 8, 0, 1'b0));
    end

    // Prescale corners: zero behaves as one, and the maximum.
    send(8'h81, 1'b0, 1'b0, 4'd0, make_exp(8'h81, 1'b0, 1'b0, 1, 0, 1'b0));
    send(8'h7E, 1'b1, 1'b1, 4'd0, make_exp(8'h7E, 1'b1, 1'b1, 1, 0, 1'b0));
    send(8'h35, 1'b1, 1'b0, 4'd1, make_exp(8'h35, 1'b1, 1'b0, 1, 0, 1'b0));
    send(8'hF0, 1'b1, 1'b0, 4'd15, make_exp(8'hF0, 1'b1, 1'b0, 15, 0, 1'b0));

    wait_idle();
    repeat (5) @(posedge Clk);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_tx_top
`default_nettype wire
